// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// Optional parity support is selected with FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-cycle counter: counts 0..limit, flags the last cycle, then wraps.
// clr forces the count back to zero to align with a new frame.
module baud_cnt #(
  parameter int DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [DVSR_WIDTH-1:0] limit,
  output logic                  bit_end
);

  logic [DVSR_WIDTH-1:0] cnt_q;

  assign bit_end = (cnt_q == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops FIFO words and sends each as a UART frame on tx.
// Define FIFO_UART_TX_PARITY_EN to add a parity bit and parity_odd.
import fifo_uart_pkg::*;

module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DVSR_WIDTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DVSR_WIDTH-1:0] dvsr,
`ifdef FIFO_UART_TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done_tick
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  clr, bit_end, last_stop, pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  baud_cnt #(.DVSR_WIDTH(DVSR_WIDTH)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .limit   (dvsr_q),
    .bit_end (bit_end)
  );

  assign last_stop = (state_q == STOP) && bit_end &&
                     (stop_q == 1'(STOP_BITS - 1));
  assign pop = en && !fifo_empty &&
               ((state_q == IDLE) || last_stop);

  assign fifo_rd      = pop;
  assign tx_done_tick = last_stop;
  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dvsr_d  = dvsr_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    clr     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        clr  = 1'b1;
        tx_d = TX_IDLE_LEVEL;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = TX_IDLE_LEVEL;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = TX_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = IDLE;
            tx_d    = TX_IDLE_LEVEL;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE_LEVEL;
      end
    endcase
    // A pop overrides the frame end so back-to-back frames have no gap.
    if (pop) begin
      state_d = START;
      shreg_d = fifo_r_data;
      dvsr_d  = dvsr;
      clr     = 1'b1;
      tx_d    = START_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = (^fifo_r_data) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dvsr_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= TX_IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dvsr_q  <= dvsr_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a small FIFO model.
// Parity frames are exercised when FIFO_UART_TX_PARITY_EN is defined.
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] dvsr;
  logic        parity_odd;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic        tx_done_tick;

  logic [7:0] mem [16];
  int wr = 0;
  int rd = 0;
  int errors = 0;
  int checks = 0;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  always #5 clk = ~clk;

  assign fifo_empty  = (wr == rd);
  assign fifo_r_data = mem[rd[3:0]];

  always @(posedge clk) begin
    if (fifo_rd) rd <= rd + 1;
  end

  fifo_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .dvsr         (dvsr),
`ifdef FIFO_UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr[3:0]] = v;
    wr = wr + 1;
  endtask

  // Called at the negedge of the pop cycle; checks every cycle of the frame.
  task automatic frame(input logic [7:0] d, input int dv,
                       input logic next_pop, input int nd);
    logic lvl;
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0) lvl = 1'b0;
      else if (k <= 8) lvl = d[k-1];
      else if (k == NBITS - 1) lvl = 1'b1;
      else lvl = (^d) ^ parity_odd;
      for (int c = 0; c <= dv; c++) begin
        @(negedge clk);
        chk($sformatf("tx_b%0d_c%0d", k, c), 32'(tx), 32'(lvl));
        chk("busy_frame", 32'(busy), 32'd1);
        if (k == 0 && c == 0) begin
          chk("rd_single", 32'(fifo_rd), 32'd0);
          if (nd >= 0) dvsr = 16'(nd);
        end
        if (k == NBITS - 1 && c == dv) begin
          chk("done_tick", 32'(tx_done_tick), 32'd1);
          chk("rd_at_end", 32'(fifo_rd), 32'(next_pop));
        end else begin
          chk("done_quiet", 32'(tx_done_tick), 32'd0);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    dvsr = 16'd3;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done_tick), 32'd0);
    reset = 1'b0;

    // en low with data waiting: nothing moves
    push(8'hA5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("en0_rd", 32'(fifo_rd), 32'd0);
      chk("en0_tx", 32'(tx), 32'd1);
      chk("en0_busy", 32'(busy), 32'd0);
    end

    // single 0xA5 frame, dvsr=3
    en = 1'b1;
    #1 chk("pop_a5", 32'(fifo_rd), 32'd1);
    frame(8'hA5, 3, 1'b0, -1);
    @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // back-to-back, dvsr=0
    en = 1'b0;
    dvsr = 16'd0;
    push(8'h01);
    push(8'hFF);
    push(8'h80);
    @(negedge clk);
    en = 1'b1;
    #1 chk("pop_01", 32'(fifo_rd), 32'd1);
    frame(8'h01, 0, 1'b1, -1);
    frame(8'hFF, 0, 1'b1, -1);
    frame(8'h80, 0, 1'b0, -1);
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    // dvsr changes mid-frame; only the next frame sees it
    dvsr = 16'd3;
    push(8'h3C);
    push(8'hC3);
    #1 chk("pop_3c", 32'(fifo_rd), 32'd1);
    frame(8'h3C, 3, 1'b1, 7);
    frame(8'hC3, 7, 1'b0, -1);
    @(negedge clk);
    chk("dv_idle", 32'(busy), 32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
    dvsr = 16'd1;
    parity_odd = 1'b0;
    push(8'h07);
    #1 chk("pop_p0", 32'(fifo_rd), 32'd1);
    frame(8'h07, 1, 1'b0, -1);
    @(negedge clk);
    parity_odd = 1'b1;
    push(8'h07);
    #1 chk("pop_p1", 32'(fifo_rd), 32'd1);
    frame(8'h07, 1, 1'b0, -1);
    @(negedge clk);
    dvsr = 16'd3;
`endif

    // reset in the middle of DATA
    push(8'h55);
    #1 chk("pop_55", 32'(fifo_rd), 32'd1);
    repeat (12) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_tx", 32'(tx), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(tx_done_tick), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rd", 32'(fifo_rd), 32'd0);
      chk("post_tx", 32'(tx), 32'd1);
      chk("post_done", 32'(tx_done_tick), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
